// File: rtl/ram_loader.sv
// Writable parameter store: loads NUM_ELEMENTS words over valid/ready, then serves registered reads.
// Optional running checksum of written words when RAM_LOADER_CHECKSUM_EN is defined.
module ram_loader #(
  parameter type T            = logic signed [15:-16],
  parameter int  NUM_ELEMENTS = 10,
  localparam int W            = $bits(T),
  localparam int AW           = $clog2(NUM_ELEMENTS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          loaded,
  output logic [AW:0]   load_count,
  input  logic          enable,
  input  logic [AW-1:0] address,
  output logic [W-1:0]  out,
`ifdef RAM_LOADER_CHECKSUM_EN
  output logic [W-1:0]  checksum,
`endif
  output logic [1:0]    debug_state
);

  // Handshake: a beat is transferred on a clock edge where in_valid && in_ready;
  // in_ready depends only on the state register, and in_data must be stable while in_valid is high.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   count_d;
  logic          loaded_d;
  logic          beat;
  logic          wr_en;
  logic [W-1:0]  elements [NUM_ELEMENTS];

  assign in_ready    = (state_q == LOAD);
  assign beat        = in_valid && in_ready;
  assign debug_state = state_q;

  always_comb begin
    state_d  = state_q;
    count_d  = load_count;
    loaded_d = loaded;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        // A restart wins over a beat arriving in the same cycle; that beat is dropped.
        if (start) begin
          count_d = '0;
        end else if (beat) begin
          wr_en   = 1'b1;
          count_d = load_count + (AW+1)'(1);
          if (load_count == (AW+1)'(NUM_ELEMENTS - 1)) begin
            state_d  = READY;
            loaded_d = 1'b1;
          end
        end
      end
      READY: begin
        if (start) begin
          state_d  = LOAD;
          count_d  = '0;
          loaded_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        count_d  = '0;
        loaded_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      load_count <= '0;
      loaded     <= 1'b0;
      out        <= '0;
    end else begin
      state_q    <= state_d;
      load_count <= count_d;
      loaded     <= loaded_d;
      if (enable && loaded) begin
        if ({1'b0, address} < (AW+1)'(NUM_ELEMENTS))
          out <= elements[address];
        else
          out <= '0;
      end
    end
  end

  // Storage has no reset; stale contents are unreachable until loaded is set again.
  always_ff @(posedge clock) begin
    if (wr_en)
      elements[load_count[AW-1:0]] <= in_data;
  end

`ifdef RAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset || start)
      checksum <= '0;
    else if (wr_en)
      checksum <= checksum + in_data;
  end
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader (NUM_ELEMENTS = 4) plus a 5-element instance for out-of-range reads.
module tb_ram_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        enable = 1'b0;
  logic [1:0]  address = '0;
  logic        enable5 = 1'b0;
  logic [2:0]  address5 = '0;

  logic        in_ready, loaded, in_ready5, loaded5;
  logic [2:0]  load_count;
  logic [3:0]  load_count5;
  logic [31:0] out, out5;
  logic [1:0]  debug_state, debug_state5;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [31:0] checksum, checksum5;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp5_q[$];
  logic        rd_req = 1'b0, rd_tag = 1'b0;
  logic        rd_req5 = 1'b0, rd_tag5 = 1'b0;

  ram_loader #(.NUM_ELEMENTS(4)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .loaded(loaded), .load_count(load_count),
    .enable(enable), .address(address), .out(out),
`ifdef RAM_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .debug_state(debug_state)
  );

  ram_loader #(.NUM_ELEMENTS(5)) dut5 (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready5), .in_data(in_data), .loaded(loaded5), .load_count(load_count5),
    .enable(enable5), .address(address5), .out(out5),
`ifdef RAM_LOADER_CHECKSUM_EN
    .checksum(checksum5),
`endif
    .debug_state(debug_state5)
  );

  // Clock and reset
  always #5 clock = ~clock;

  // Scoreboard monitors: a read issued before an edge is compared at the following negedge
  always @(posedge clock) begin
    rd_tag  <= rd_req;
    rd_tag5 <= rd_req5;
  end

  always @(negedge clock) begin
    if (rd_tag) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL read4: out=%h with no expected value queued", out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out !== e) begin
          failures++;
          $display("FAIL read4: got %h expected %h", out, e);
        end
      end
    end
    if (rd_tag5) begin
      checks++;
      if (exp5_q.size() == 0) begin
        failures++;
        $display("FAIL read5: out=%h with no expected value queued", out5);
      end else begin
        logic [31:0] e;
        e = exp5_q.pop_front();
        if (out5 !== e) begin
          failures++;
          $display("FAIL read5: got %h expected %h", out5, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic read4(input logic [1:0] a, input logic [31:0] e);
    enable  = 1'b1;
    address = a;
    rd_req  = 1'b1;
    exp_q.push_back(e);
    tick();
    enable = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic read5(input logic [2:0] a, input logic [31:0] e);
    enable5  = 1'b1;
    address5 = a;
    rd_req5  = 1'b1;
    exp5_q.push_back(e);
    tick();
    enable5 = 1'b0;
    rd_req5 = 1'b0;
  endtask

  logic [31:0] w1 [4] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h7FFF_FFFF};
  logic [31:0] w2 [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
  logic        v2 [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int k;
    tick();
    tick();
    reset = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_loaded", {31'b0, loaded}, 32'd0);
    check("rst_load_count", {29'b0, load_count}, 32'd0);
    check("rst_state", {30'b0, debug_state}, 32'd0);
    check("rst_out", out, 32'd0);

    // Test 1: consecutive load, read-back; not-loaded reads hold out at 0
    pulse_start();
    check("t1_in_ready", {31'b0, in_ready}, 32'd1);
    check("t1_state", {30'b0, debug_state}, 32'd1);
    check("t1_count0", {29'b0, load_count}, 32'd0);
    read4(2'd2, 32'd0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w1[i];
      tick();
      check("t1_count", {29'b0, load_count}, i + 1);
      check("t1_loaded", {31'b0, loaded}, (i == 3) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    check("t1_ready_low", {31'b0, in_ready}, 32'd0);
    check("t1_state_ready", {30'b0, debug_state}, 32'd2);
    // Fifth word completes the 5-element instance; the full 4-element one must ignore it
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    check("t1_count_hold", {29'b0, load_count}, 32'd4);
    check("t1_loaded5", {31'b0, loaded5}, 32'd1);
    check("t1_count5", {28'b0, load_count5}, 32'd5);
    for (int i = 0; i < 4; i++) read4(2'(i), w1[i]);
    read5(3'd4, 32'h1234_5678);
    read5(3'd7, 32'd0);
    read5(3'd0, w1[0]);
    read5(3'd5, 32'd0);

    // Test 2: gapped in_valid
    pulse_start();
    check("t2_loaded_clr", {31'b0, loaded}, 32'd0);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = v2[i];
      in_data  = v2[i] ? w2[k] : 32'hDEAD_BEEF;
      tick();
      if (v2[i]) k++;
      check("t2_count", {29'b0, load_count}, k);
      check("t2_loaded", {31'b0, loaded}, (k == 4) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) read4(2'(i), w2[i]);

    // Test 3: restart coincident with the third beat
    pulse_start();
    send_word(32'hAAAA_0000);
    send_word(32'hBBBB_0000);
    in_valid = 1'b1;
    in_data  = 32'hCCCC_0000;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("t3_count_restart", {29'b0, load_count}, 32'd0);
    check("t3_in_ready", {31'b0, in_ready}, 32'd1);
    check("t3_loaded", {31'b0, loaded}, 32'd0);
    for (int i = 1; i <= 4; i++) send_word(32'(i));
    check("t3_loaded_done", {31'b0, loaded}, 32'd1);
    for (int i = 0; i < 4; i++) read4(2'(i), 32'(i + 1));

    // Test 5: reset mid-load, then a clean load
    pulse_start();
    send_word(32'h0000_0055);
    send_word(32'h0000_0066);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_state", {30'b0, debug_state}, 32'd0);
    check("t5_loaded", {31'b0, loaded}, 32'd0);
    check("t5_out", out, 32'd0);
    check("t5_in_ready", {31'b0, in_ready}, 32'd0);
    check("t5_count", {29'b0, load_count}, 32'd0);
    read4(2'd1, 32'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(32'h9 + 32'(i));
    check("t5_loaded_done", {31'b0, loaded}, 32'd1);
    for (int i = 0; i < 4; i++) read4(2'(3 - i), 32'h9 + 32'(3 - i));

`ifdef RAM_LOADER_CHECKSUM_EN
    // Test 6: checksum accumulation, freeze in READY, clear on start
    pulse_start();
    check("t6_sum_clr", checksum, 32'd0);
    send_word(32'h0002_0000);
    send_word(32'hDEAD_0000);
    in_valid = 1'b1;
    in_data  = 32'h0F0F_0000;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("t6_sum_restart", checksum, 32'd0);
    send_word(32'h0001_0000);
    send_word(32'h0002_0000);
    send_word(32'hFFFF_0000);
    send_word(32'h0000_0001);
    check("t6_sum", checksum, 32'h0002_0001);
    in_valid = 1'b1;
    in_data  = 32'h0000_0100;
    tick();
    in_valid = 1'b0;
    check("t6_sum_frozen", checksum, 32'h0002_0001);
    pulse_start();
    check("t6_sum_start", checksum, 32'd0);
`endif

    tick();
    tick();
    check("queue_empty", 32'(exp_q.size() + exp5_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
